// File: rtl/psum_deskew_collector_pkg.sv
// psum_deskew_collector_pkg: shared lane slicing, default width and fifo count sizing
package psum_deskew_collector_pkg;
    localparam int PSUM_BW_DEFAULT = 21;
    function automatic int lane_off(input int lane, input int bw);
        return lane * bw;
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/deskew_fifo.sv
// deskew_fifo: synchronous fifo with a registered, reset head register
module deskew_fifo import psum_deskew_collector_pkg::*; #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_n;
    logic          do_push, do_pop;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rptr_n  = rptr + AW'(do_pop);
    end
    always_ff @(posedge clk)
        if (do_push && !clear) mem[wptr] <= din;
    // head is preloaded with the entry that will sit at rptr next cycle, bypassing din when it lands there
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr_n;
            count <= count + CW'(do_push) - CW'(do_pop);
            dout  <= (do_push && wptr == rptr_n) ? din : mem[rptr_n];
        end
endmodule

// File: rtl/psum_deskew_collector.sv
// psum_deskew_collector: removes per-row psum skew and buffers aligned vectors for writeback
module psum_deskew_collector import psum_deskew_collector_pkg::*; #(
    parameter int ROWS           = 32,
    parameter int PARTIAL_SUM_BW = PSUM_BW_DEFAULT,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clear,
    input  logic                              psum_in_valid,
    input  logic [ROWS*PARTIAL_SUM_BW-1:0]    psum_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ROWS*PARTIAL_SUM_BW-1:0]    out_data,
    output logic [cnt_w(FIFO_DEPTH)-1:0]      fifo_count,
    output logic                              overflow
);
    logic [ROWS*PARTIAL_SUM_BW-1:0] aligned;
    logic [ROWS-1:0]                vsr;
    logic                           aligned_valid, full, empty, pop;
    assign aligned_valid = vsr[ROWS-1];
    assign out_valid     = !empty;
    assign pop           = out_valid && out_ready;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) vsr <= '0;
        else if (clear) vsr <= '0;
        else vsr <= ROWS'({vsr, psum_in_valid});
    // lane g leaves the array g cycles late, so it needs g fewer registers than lane 0
    for (genvar g = 0; g < ROWS; g++) begin : g_lane
        logic [PARTIAL_SUM_BW-1:0] dl [ROWS-g];
        always_ff @(posedge clk) begin
            dl[0] <= psum_in[lane_off(g, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW];
            for (int k = 1; k < ROWS - g; k++) dl[k] <= dl[k-1];
        end
        assign aligned[lane_off(g, PARTIAL_SUM_BW) +: PARTIAL_SUM_BW] = dl[ROWS-g-1];
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) overflow <= 1'b0;
        else if (clear) overflow <= 1'b0;
        else if (aligned_valid && full && !pop) overflow <= 1'b1;
    deskew_fifo #(.W(ROWS*PARTIAL_SUM_BW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .push  (aligned_valid),
        .pop   (pop),
        .din   (aligned),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
endmodule
